// File: rtl/adder_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// Handshake: valid-only; in_valid qualifies in/in2 for one cycle, out_valid qualifies out and flags for one cycle; no ready/backpressure.
interface adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] in2;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             out_valid;

    modport master (
        output in, in2, in_valid,
        input  out, carry, overflow, zero, negative, out_valid
    );

    modport slave (
        input  in, in2, in_valid,
        output out, carry, overflow, zero, negative, out_valid
    );
endinterface

// File: rtl/adder.sv
// WIDTH-bit two's-complement adder built from 4-bit carry-lookahead groups,
// with registered sum, status flags and a one-stage valid pipeline.
module adder #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    adder_if.slave bus
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic             sum_ovf;

    assign g = bus.in & bus.in2;
    assign p = bus.in ^ bus.in2;

    // Group generate/propagate: a group generates if some bit generates and
    // every bit above it in the group propagates.
    always_comb begin
        grp_g = '0;
        grp_p = '1;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < 4; j++) begin
                grp_g[k] = g[4*k+j] | (p[4*k+j] & grp_g[k]);
                grp_p[k] = grp_p[k] & p[4*k+j];
            end
        end
    end

    // Flat lookahead: carry into group k+1 is the OR over all lower groups j
    // of G[j] propagated through groups j+1..k. Carry-in is tied to 0.
    always_comb begin
        logic term;
        logic run;
        term  = 1'b0;
        run   = 1'b0;
        grp_c = '0;
        for (int k = 0; k < NG; k++) begin
            term = 1'b0;
            for (int j = 0; j <= k; j++) begin
                run = grp_g[j];
                for (int m = j + 1; m <= k; m++) begin
                    run = run & grp_p[m];
                end
                term = term | run;
            end
            grp_c[k+1] = term;
        end
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < NG; k++) begin
            c[4*k] = grp_c[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
    end

    assign sum     = p ^ c;
    assign sum_ovf = (bus.in[WIDTH-1] == bus.in2[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.in[WIDTH-1]);

    // Flags are taken from the pre-register sum so they line up with out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out       <= '0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b0;
            bus.negative  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out      <= sum;
                bus.carry    <= grp_c[NG];
                bus.overflow <= sum_ovf;
                bus.zero     <= (sum == '0);
                bus.negative <= sum[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_adder.sv
// Randomized self-checking bench for adder against an arithmetic reference model.
module tb_adder;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Expected record: {carry, overflow, zero, negative, out}
    logic [W+3:0] exp_q[$];
    logic [W+3:0] held;

    adder_if #(.WIDTH(W)) bus ();

    adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        longint     sa;
        logic       ov;
        s  = {1'b0, a} + {1'b0, b};
        sa = longint'($signed(a)) + longint'($signed(b));
        ov = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
        return {s[W], ov, (s[W-1:0] == '0), s[W-1], s[W-1:0]};
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".out"},      bus.out,               held[W-1:0]);
        check_val({tag, ".carry"},    W'(bus.carry),         W'(held[W+3]));
        check_val({tag, ".overflow"}, W'(bus.overflow),      W'(held[W+2]));
        check_val({tag, ".zero"},     W'(bus.zero),          W'(held[W+1]));
        check_val({tag, ".negative"}, W'(bus.negative),      W'(held[W]));
    endtask

    // Driver: apply one cycle of operands at negedge, check 1 ns after posedge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit xin);
        @(negedge clk);
        bus.in_valid = v;
        bus.in       = xin ? 'x : a;
        bus.in2      = xin ? 'x : b;
        if (v) exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        check_val({tag, ".out_valid"}, W'(bus.out_valid), W'(v));
        if (v && exp_q.size() > 0) held = exp_q.pop_front();
        check_outputs(tag);
    endtask

    logic [W-1:0] corner [8] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_FFFF, 32'hAAAA_AAAA};

    initial begin
        checks       = 0;
        errors       = 0;
        held         = '0;
        rst          = 1'b1;
        bus.in       = '0;
        bus.in2      = '0;
        bus.in_valid = 1'b0;

        // Reset state, including a clock edge with valid operands under reset
        #2;
        check_val("reset.out_valid", W'(bus.out_valid), '0);
        check_outputs("reset");
        bus.in = 32'd5; bus.in2 = 32'd6; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check_val("reset_hold.out_valid", W'(bus.out_valid), '0);
        check_outputs("reset_hold");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;

        // Directed cases
        step("pos_add",  1'b1, 32'd10,        32'd15,        1'b0);
        step("neg_pos",  1'b1, 32'hFFFF_FFF6, 32'd15,        1'b0);
        step("pos_neg",  1'b1, 32'd20,        32'hFFFF_FFF1, 1'b0);
        step("hold",     1'b0, 32'd100,       32'd200,       1'b0);
        step("hold_x",   1'b0, 32'd0,         32'd0,         1'b1);
        step("max_pos",  1'b1, 32'h7FFF_FFFF, 32'd1,         1'b0);
        step("all_ones", 1'b1, 32'hFFFF_FFFF, 32'd1,         1'b0);
        step("min_min",  1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check_val("spec.min_min.out", bus.out, 32'h0);
        step("b2b_a",    1'b1, 32'd1,         32'd2,         1'b0);
        step("b2b_b",    1'b1, 32'd3,         32'd4,         1'b0);

        // Reset mid-stream: asynchronous clear between edges
        step("pre_rst",  1'b1, 32'd10,        32'd15,        1'b0);
        check_val("spec.pre_rst.out", bus.out, 32'd25);
        bus.in_valid = 1'b1; bus.in = 32'd1; bus.in2 = 32'd1;
        #2;
        rst = 1'b1;
        #1;
        held = '0;
        exp_q.delete();
        check_val("async_rst.out_valid", W'(bus.out_valid), '0);
        check_outputs("async_rst");
        @(posedge clk); #1;
        check_val("rst_edge.out_valid", W'(bus.out_valid), '0);
        check_outputs("rst_edge");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step("post_rst", 1'b1, 32'd3,         32'd4,         1'b0);
        check_val("spec.post_rst.out", bus.out, 32'd7);

        // Random regression
        for (int i = 0; i < 10000; i++) begin
            logic         v;
            logic [W-1:0] a;
            logic [W-1:0] b;
            v = ($urandom_range(0, 9) < 7);
            a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 7)] : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 7)] : W'($urandom);
            step("rand", v, a, b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder.md
Name: adder

Overview:
- 32-bit two's-complement adder used as the datapath ALU add/branch-target adder.
- Computes out = in + in2 and registers the sum plus status flags on the rising clock edge.
- One-cycle latency, with a simple valid pipeline so downstream logic knows when the result is fresh.
- Arithmetic is internally a 4-bit-group carry-lookahead (8 groups) rather than an inferred "+".

Parameters:
- WIDTH, 32, operand/result width in bits; all behaviour below is for 32, and the block must be correct for any WIDTH that is a multiple of 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  WIDTH  operand A, two's complement
- in2  input  WIDTH  operand B, two's complement
- in_valid  input  1  operands on in/in2 are valid this cycle
- out  output  WIDTH  registered sum in + in2, modulo 2^WIDTH
- carry  output  1  registered unsigned carry-out of bit WIDTH-1
- overflow  output  1  registered signed overflow
- zero  output  1  registered flag, 1 when out == 0
- negative  output  1  registered copy of out[WIDTH-1]
- out_valid  output  1  registered in_valid; qualifies out and the flags

Behaviour:
- Reset: rst high clears out=0, carry=0, overflow=0, zero=0, negative=0 and out_valid=0 immediately, independent of clk. It holds them there while asserted.
- Reset mid-operation: an in-flight result is discarded. The first capture happens on the first rising edge after rst deasserts.
- Datapath: each 4-bit group produces generate/propagate terms. Group carries come from lookahead logic over the group G/P. The sum bit is a^b^c per bit. No carry-in port; carry-in is 0.
- Carry: carry = carry out of the MSB (unsigned overflow).
- Overflow: overflow = (in[MSB] == in2[MSB]) && (sum[MSB] != in[MSB]).
- Zero and negative are derived from the sum before it is registered, so they are aligned with out.
- Capture: on every rising clk edge with rst low, the registers update as follows.
  - When in_valid=1: out, carry, overflow, zero and negative load the new values, and out_valid becomes 1.
  - When in_valid=0: out and all flags hold their previous values, and out_valid becomes 0.
- Latency: exactly 1 cycle from operand capture to out_valid=1.
- Throughput: one add per cycle. Back-to-back valid operands give back-to-back valid results.
- No handshake backpressure: a result is valid for the single cycle that out_valid is high. out holds its value afterwards until the next valid capture.
- Wrap-around: results are modulo 2^WIDTH, with no saturation.
  - 0x7FFFFFFF + 1 gives 0x80000000, overflow=1, carry=0.
  - 0xFFFFFFFF + 1 gives 0, carry=1, zero=1, overflow=0.
- X/undriven operands with in_valid=0 must not alter the outputs.

Test Plan:
- Positive add: in=10, in2=15, in_valid=1 -> next edge: out=25 (0x19), carry=0, overflow=0, zero=0, negative=0, out_valid=1.
- Negative plus positive: in=-10 (0xFFFFFFF6), in2=15 -> out=5, carry=1, overflow=0, zero=0, negative=0.
- Positive plus negative, then hold:
  - in=20, in2=-15 (0xFFFFFFF1) -> out=5, carry=1, overflow=0.
  - Then in_valid=0 with new operands -> out stays 5 and out_valid=0.
- Boundaries:
  - 0x7FFFFFFF+1 -> out=0x80000000, overflow=1, negative=1.
  - 0xFFFFFFFF+1 -> out=0, carry=1, zero=1.
  - 0x80000000+0x80000000 -> out=0, carry=1, overflow=1, zero=1.
- Reset mid-stream: issue valid 10+15, then assert rst between clock edges -> out=0, all flags 0 and out_valid=0 immediately (asynchronously). The first valid operands after deassertion appear 1 cycle later.
- Random regression: 10k random valid/invalid cycles, compared against a reference model of the sum mod 2^32 and the flag equations above, at 1-cycle latency.
